// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Brief    : Programmable performance-monitor bank. Per-cycle event
//            increments are registered once (E1) and then accumulated into
//            CNT_NUM counters, each selecting one event. Counters, configs
//            and the W1C overflow status sit behind a request/response
//            register port. A level interrupt flags enabled overflows.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
  parameter  int EVENT_NUM = 16,
  parameter  int INC_WIDTH = 3,
  parameter  int CNT_NUM   = 4,
  parameter  int CNT_WIDTH = 48,
  localparam int ADDR_W    = $clog2(2*CNT_NUM+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] evt_inc,
  input  logic                           inhibit,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [CNT_WIDTH-1:0]           req_wdata,
  output logic                           rsp_valid,
  output logic [CNT_WIDTH-1:0]           rsp_data,
  output logic                           ovf_irq
);

  localparam logic [ADDR_W-1:0] C_STAT_ADDR = ADDR_W'(2*CNT_NUM);

  // Event pipeline stage E1
  logic [EVENT_NUM*INC_WIDTH-1:0] evt_q, evt_d;
  logic                           inhibit_q, inhibit_d;

  // Per-counter views collected from the generate block for the read mux
  logic [CNT_WIDTH-1:0] cnt_val [CNT_NUM];
  logic [CNT_WIDTH-1:0] cfg_val [CNT_NUM];
  logic [CNT_NUM-1:0]   irq_en_vec;
  logic [CNT_NUM-1:0]   ovf_set;

  // Shared status, interrupt and response state
  logic [CNT_NUM-1:0]   ovf_q, ovf_d;
  logic [CNT_NUM-1:0]   ovf_clr;
  logic                 ovf_irq_q, ovf_irq_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CNT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_WIDTH-1:0] rd_val;

  logic wr_en;
  logic rd_en;

  // No backpressure: every presented request is taken.
  assign req_ready = 1'b1;
  assign wr_en     = req_valid & req_we;
  assign rd_en     = req_valid & ~req_we;

  // E1 simply captures the raw event increments and the freeze flag
  always_comb begin
    evt_d     = evt_inc;
    inhibit_d = inhibit;
  end

  // E1 registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_q     <= '0;
      inhibit_q <= 1'b0;
    end else begin
      evt_q     <= evt_d;
      inhibit_q <= inhibit_d;
    end
  end

  for (genvar k = 0; k < CNT_NUM; k++) begin : g_cnt
    localparam logic [ADDR_W-1:0] C_CNT_ADDR = ADDR_W'(k);
    localparam logic [ADDR_W-1:0] C_CFG_ADDR = ADDR_W'(CNT_NUM + k);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 irq_en_q, irq_en_d;
    logic [INC_WIDTH-1:0] inc_sel;
    logic [CNT_WIDTH:0]   sum;
    logic                 set_k;
    logic                 cnt_wr;
    logic                 cfg_wr;

    assign cnt_wr = wr_en && (req_addr == C_CNT_ADDR);
    assign cfg_wr = wr_en && (req_addr == C_CFG_ADDR);

    // Pick the selected event's E1 increment; out-of-range selects add 0
    always_comb begin
      inc_sel = '0;
      for (int e = 0; e < EVENT_NUM; e++) begin
        if (sel_q == 8'(e)) begin
          inc_sel = evt_q[e*INC_WIDTH +: INC_WIDTH];
        end
      end
    end

    // Next counter value: a register write overrides this cycle's increment
    always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_sel);
      cnt_d = cnt_q;
      set_k = 1'b0;
      if (cnt_wr) begin
        cnt_d = req_wdata;
      end else if (en_q && !inhibit_q) begin
        cnt_d = sum[CNT_WIDTH-1:0];
        set_k = sum[CNT_WIDTH];
      end
    end

    // Next config: only the defined fields are kept
    always_comb begin
      sel_d    = sel_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      if (cfg_wr) begin
        sel_d    = req_wdata[7:0];
        en_d     = req_wdata[16];
        irq_en_d = req_wdata[17];
      end
    end

    // Counter and config registers
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q    <= '0;
        sel_q    <= '0;
        en_q     <= 1'b0;
        irq_en_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        sel_q    <= sel_d;
        en_q     <= en_d;
        irq_en_q <= irq_en_d;
      end
    end

    assign cnt_val[k]    = cnt_q;
    assign cfg_val[k]    = CNT_WIDTH'({irq_en_q, en_q, 8'h00, sel_q});
    assign irq_en_vec[k] = irq_en_q;
    assign ovf_set[k]    = set_k;
  end

  // Overflow status: W1C clear, with a same-cycle set taking priority
  always_comb begin
    ovf_clr = '0;
    if (wr_en && (req_addr == C_STAT_ADDR)) begin
      ovf_clr = req_wdata[CNT_NUM-1:0];
    end
    ovf_d     = (ovf_q & ~ovf_clr) | ovf_set;
    ovf_irq_d = |(ovf_q & irq_en_vec);
  end

  // Read mux over the register map; unmapped addresses return 0
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < CNT_NUM; k++) begin
      if (req_addr == ADDR_W'(k)) begin
        rd_val = cnt_val[k];
      end
      if (req_addr == ADDR_W'(CNT_NUM + k)) begin
        rd_val = cfg_val[k];
      end
    end
    if (req_addr == C_STAT_ADDR) begin
      rd_val = CNT_WIDTH'(ovf_q);
    end
  end

  // Response carries the pre-update register value; writes return 0
  always_comb begin
    rsp_valid_d = req_valid;
    rsp_data_d  = rd_en ? rd_val : '0;
  end

  // Status, interrupt and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q       <= '0;
      ovf_irq_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ovf_q       <= ovf_d;
      ovf_irq_q   <= ovf_irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ovf_irq   = ovf_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_counter_bank
// Brief    : Directed and randomized bench for perf_counter_bank against a
//            cycle-level behavioural model of the counter bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;
  localparam int EVENT_NUM = 16;
  localparam int INC_WIDTH = 3;
  localparam int CNT_NUM   = 4;
  localparam int CNT_WIDTH = 48;
  localparam int ADDR_W    = $clog2(2*CNT_NUM+1);
  localparam bit [63:0] MAXV = (64'd1 << CNT_WIDTH) - 64'd1;
  localparam int STAT = 2*CNT_NUM;

  logic                           clk;
  logic                           rst;
  logic [EVENT_NUM*INC_WIDTH-1:0] evt_inc;
  logic                           inhibit;
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_we;
  logic [ADDR_W-1:0]              req_addr;
  logic [CNT_WIDTH-1:0]           req_wdata;
  logic                           rsp_valid;
  logic [CNT_WIDTH-1:0]           rsp_data;
  logic                           ovf_irq;

  perf_counter_bank #(
    .EVENT_NUM (EVENT_NUM),
    .INC_WIDTH (INC_WIDTH),
    .CNT_NUM   (CNT_NUM),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_inc   (evt_inc),
    .inhibit   (inhibit),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ovf_irq   (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus state
  int ev [EVENT_NUM];
  bit inh;

  // Behavioural model state
  bit [63:0]          m_cnt [CNT_NUM];
  int                 m_sel [CNT_NUM];
  bit                 m_en  [CNT_NUM];
  bit                 m_ie  [CNT_NUM];
  bit [CNT_NUM-1:0]   m_ovf;
  int                 m_pev [EVENT_NUM];
  bit                 m_pinh;
  bit                 m_rv;
  bit [63:0]          m_rd;
  bit                 m_irq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [63:0] model_read(input int a);
    if (a < CNT_NUM)
      return m_cnt[a];
    else if (a < 2*CNT_NUM)
      return (64'(m_ie[a-CNT_NUM]) << 17) | (64'(m_en[a-CNT_NUM]) << 16) | 64'(m_sel[a-CNT_NUM]);
    else if (a == STAT)
      return 64'(m_ovf);
    else
      return 64'd0;
  endfunction

  // One clock: drive inputs, advance the model, compare outputs after the edge
  task automatic tick();
    bit [63:0]        n_cnt [CNT_NUM];
    int               n_sel [CNT_NUM];
    bit               n_en  [CNT_NUM];
    bit               n_ie  [CNT_NUM];
    bit [CNT_NUM-1:0] n_ovf, set_v;
    bit               n_rv, n_irq;
    bit [63:0]        n_rd;
    int               a, add;
    for (int i = 0; i < EVENT_NUM; i++) evt_inc[i*INC_WIDTH +: INC_WIDTH] = INC_WIDTH'(ev[i]);
    inhibit = inh;
    if (!rst) begin
      for (int k = 0; k < CNT_NUM; k++) begin
        n_cnt[k] = 0; n_sel[k] = 0; n_en[k] = 0; n_ie[k] = 0;
      end
      n_ovf = 0; n_rv = 0; n_rd = 0; n_irq = 0;
      for (int i = 0; i < EVENT_NUM; i++) m_pev[i] = 0;
      m_pinh = 0;
    end else begin
      n_rv  = req_valid;
      n_rd  = (req_valid && !req_we) ? model_read(int'(req_addr)) : 64'd0;
      n_irq = 0;
      set_v = 0;
      for (int k = 0; k < CNT_NUM; k++) begin
        if (m_ovf[k] && m_ie[k]) n_irq = 1;
        n_cnt[k] = m_cnt[k]; n_sel[k] = m_sel[k]; n_en[k] = m_en[k]; n_ie[k] = m_ie[k];
        if (m_en[k] && !m_pinh) begin
          add = (m_sel[k] < EVENT_NUM) ? m_pev[m_sel[k]] : 0;
          if (m_cnt[k] + 64'(add) > MAXV) begin
            n_cnt[k] = m_cnt[k] + 64'(add) - (MAXV + 64'd1);
            set_v[k] = 1;
          end else begin
            n_cnt[k] = m_cnt[k] + 64'(add);
          end
        end
      end
      n_ovf = m_ovf;
      if (req_valid && req_we) begin
        a = int'(req_addr);
        if (a < CNT_NUM) begin
          n_cnt[a] = 64'(req_wdata);
          set_v[a] = 0;
        end else if (a < 2*CNT_NUM) begin
          n_sel[a-CNT_NUM] = int'(req_wdata[7:0]);
          n_en[a-CNT_NUM]  = req_wdata[16];
          n_ie[a-CNT_NUM]  = req_wdata[17];
        end else if (a == STAT) begin
          n_ovf = n_ovf & ~req_wdata[CNT_NUM-1:0];
        end
      end
      n_ovf = n_ovf | set_v;
      m_pev  = ev;
      m_pinh = inh;
    end
    @(posedge clk);
    m_cnt = n_cnt; m_sel = n_sel; m_en = n_en; m_ie = n_ie;
    m_ovf = n_ovf; m_rv = n_rv; m_rd = n_rd; m_irq = n_irq;
    #1;
    check("req_ready", req_ready, 1);
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_data",  rsp_data,  m_rd);
    check("ovf_irq",   ovf_irq,   m_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int a, input bit [63:0] d);
    req_valid = 1; req_we = 1; req_addr = ADDR_W'(a); req_wdata = CNT_WIDTH'(d);
    tick();
    req_valid = 0; req_we = 0;
  endtask

  task automatic rd(input int a, output bit [63:0] d);
    req_valid = 1; req_we = 0; req_addr = ADDR_W'(a);
    tick();
    req_valid = 0;
    d = 64'(rsp_data);
  endtask

  initial begin
    bit [63:0] d;
    int a;
    rst = 0; inh = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; evt_inc = '0; inhibit = 0;
    idle(2);
    rst = 1;
    for (int i = 0; i <= STAT; i++) begin
      rd(i, d); check("reset_read", d, 0);
    end

    // 1: basic accumulation and two-cycle event latency
    wr(CNT_NUM+0, (64'd1 << 16) | 64'd2);
    ev[2] = 5;
    rd(0, d); check("t1_lat0", d, 0);
    rd(0, d); check("t1_lat1", d, 0);
    rd(0, d); check("t1_lat2", d, 5);
    idle(7);
    ev[2] = 0;
    idle(2);
    rd(0, d); check("t1_total", d, 50);

    // 2: overflow wrap, status, interrupt and W1C clear
    wr(1, MAXV - 64'd2);
    wr(CNT_NUM+1, (64'd3 << 16));
    ev[0] = 4; tick(); ev[0] = 0;
    idle(2);
    check("t2_irq_set", ovf_irq, 1);
    rd(1, d); check("t2_wrapped", d, 1);
    rd(STAT, d); check("t2_status", d, 2);
    wr(STAT, 2);
    tick();
    check("t2_irq_clr", ovf_irq, 0);
    rd(STAT, d); check("t2_status_clr", d, 0);

    // 3: write beats same-cycle increment
    wr(CNT_NUM+2, (64'd1 << 16) | 64'd3);
    ev[3] = 7;
    idle(3);
    wr(2, 100);
    rd(2, d); check("t3_write_wins", d, 100);
    rd(2, d); check("t3_resume", d, 107);
    ev[3] = 0;

    // 4: inhibit freezes counting
    wr(CNT_NUM+0, (64'd1 << 16) | 64'd1);
    ev[1] = 1; inh = 1;
    idle(2);
    wr(0, 0);
    idle(20);
    rd(0, d); check("t4_frozen", d, 0);
    inh = 0;
    idle(2);
    rd(0, d); check("t4_resume1", d, 1);
    rd(0, d); check("t4_resume2", d, 2);
    ev[1] = 0;

    // 5: unmapped address and out-of-range select
    rd(STAT+1, d); check("t5_unmapped", d, 0);
    wr(CNT_NUM+3, (64'd1 << 16) | 64'd200);
    wr(3, 0);
    for (int i = 0; i < EVENT_NUM; i++) ev[i] = 7;
    idle(5);
    rd(3, d); check("t5_sel_oob", d, 0);
    rd(CNT_NUM+3, d); check("t5_cfg_read", d, (64'd1 << 16) | 64'd200);
    for (int i = 0; i < EVENT_NUM; i++) ev[i] = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < EVENT_NUM; i++) ev[i] = int'($urandom_range(0, 7));
      inh       = ($urandom_range(0, 7) == 0);
      req_valid = $urandom_range(0, 1);
      req_we    = $urandom_range(0, 1);
      a         = int'($urandom_range(0, (1 << ADDR_W) - 1));
      req_addr  = ADDR_W'(a);
      if (a < CNT_NUM && $urandom_range(0, 1) == 1)
        req_wdata = CNT_WIDTH'(MAXV - 64'($urandom_range(0, 30)));
      else if (a >= CNT_NUM && a < 2*CNT_NUM)
        req_wdata = CNT_WIDTH'((64'($urandom) & 64'hFFFC_FF00) | (64'($urandom_range(0, 3)) << 16) | 64'($urandom_range(0, 17)));
      else
        req_wdata = CNT_WIDTH'({$urandom, $urandom});
      tick();
    end
    req_valid = 0; req_we = 0; inh = 0;
    for (int i = 0; i < EVENT_NUM; i++) ev[i] = 0;
    idle(2);

    // 6: reset during back-to-back responses
    req_valid = 1; req_we = 0; req_addr = ADDR_W'(0);
    tick();
    check("t6_rsp1", rsp_valid, 1);
    req_addr = ADDR_W'(1);
    tick();
    check("t6_rsp2", rsp_valid, 1);
    rst = 0; req_addr = ADDR_W'(2);
    tick();
    check("t6_rsp3_dropped", rsp_valid, 0);
    rst = 1; req_valid = 0;
    for (int i = 0; i <= STAT; i++) begin
      rd(i, d); check("t6_post_reset", d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Programmable hardware performance-monitor bank that consumes per-cycle event increments from core stages (fetch, rename, commit, dcache, scb) and accumulates them into CNT_NUM selectable counters. Software or debug logic reads and writes counters, configuration and overflow status over a simple request/response register port. The bank raises a level overflow interrupt. It sits between the event producers and the CSR/debug interconnect.

Parameters:
EVENT_NUM, 16, number of event inputs (must be ≤ 256)
INC_WIDTH, 3, width of each event's per-cycle increment (0..7 per cycle)
CNT_NUM, 4, number of counters
CNT_WIDTH, 48, counter and data-bus width (must be ≥ 18)
ADDR_W, localparam = $clog2(2*CNT_NUM+1), register address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (bank resets on a posedge clk where rst==0)
evt_inc  in  EVENT_NUM*INC_WIDTH  packed increments; event i is bits [i*INC_WIDTH +: INC_WIDTH]
inhibit  in  1  global freeze; while 1, no counter increments
req_valid  in  1  register access request
req_ready  out  1  request can be accepted
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  register address
req_wdata  in  CNT_WIDTH  write data
rsp_valid  out  1  response pulse (reads and writes)
rsp_data  out  CNT_WIDTH  read data (0 for writes)
ovf_irq  out  1  overflow interrupt, level

Behaviour:
- Reset: all counters 0, all configs 0 (disabled), ovf status 0, event pipeline register 0, rsp_valid 0, rsp_data 0, ovf_irq 0. req_ready is 1 on the first cycle after reset.
- Address map:
  - 0..CNT_NUM-1: counter k value.
  - CNT_NUM+k: config k, with [7:0] sel, [16] en, [17] irq_en; other bits write-ignored and read 0.
  - 2*CNT_NUM: overflow status, bit k = counter k overflowed; writing 1 clears that bit (W1C).
  - Any other address reads 0, ignores writes, and still responds.
- Event pipeline: evt_inc and inhibit are registered once (stage E1).
  - In the next cycle, counter k adds the E1 increment of event sel_k, zero-extended, if en_k && !inhibit_E1.
  - An evt_inc change is visible in a counter read 2 cycles later.
  - sel_k ≥ EVENT_NUM adds 0.
- Handshake:
  - req_ready = 1 always; there is no backpressure.
  - A request is accepted at the posedge where req_valid==1.
  - rsp_valid is asserted exactly 1 cycle after acceptance, for 1 cycle. Back-to-back requests give back-to-back responses.
  - Read data is the register value held at the accepting edge, i.e. before that cycle's increment/write.
- Write vs increment, same cycle on the same counter: the write wins and that cycle's increment is dropped. The counter equals wdata truncated to CNT_WIDTH.
- Config write takes effect on increments from the next cycle.
- Overflow:
  - Counter add is modulo 2^CNT_WIDTH.
  - When an increment carries out of bit CNT_WIDTH-1, ovf[k] is set and the counter holds the wrapped value.
  - Set beats a W1C clear in the same cycle.
- ovf_irq is registered: ovf_irq <= |(ovf & irq_en), so it lags the ovf update by 1 cycle.
- Reset asserted mid-operation: any in-flight response is dropped (rsp_valid 0 next cycle). All state returns to reset values; requests presented during reset are not accepted.

Test Plan:
1. Config0 ← en=1, sel=2; drive event 2 = 5 for 10 cycles, then 0 → counter0 reads 50. The first increment appears in a read 2 cycles after the first evt_inc. rsp_valid pulses 1 cycle after each request.
2. Counter1 ← CNT_WIDTH all-ones minus 2 (2^48-3), config1 ← en=1, irq_en=1, sel=0; event 0 = 4 for one cycle → counter1 = 1, ovf status = 0b0010, ovf_irq = 1 one cycle later. W1C 0b0010 → status 0, ovf_irq 0 next cycle.
3. Event 3 = 7 every cycle on counter2 (sel=3, en=1); write counter2 ← 100 → read right after returns 100 (+7 per subsequent cycle), not 107.
4. Counter0 enabled with event 1 = 1 every cycle; hold inhibit = 1 for 20 cycles → counter0 unchanged across the window, then resumes +1/cycle.
5. Read address 2*CNT_NUM+1 and config sel=200 → reads return 0; a sel=200 counter stays 0 under all-ones events.
6. Back-to-back reads on 3 consecutive cycles, then rst=0 for one cycle during the second response → the third response is absent; all registers read 0 after reset.
